// File: rtl/paper_sequencer.sv
// Purpose : tiny 4-opcode sequencer with a 16x8 program memory and four 8-bit data registers.
// Latency : every executed instruction takes 2 cycles (FETCH then EXEC). HALTED is reached 2 cycles after an STP is fetched.
// Backpressure: none. start and load_en are honoured only in IDLE (start also in HALTED) and ignored while busy.
//
// Ports:
//   clk, rst_n                      clock and synchronous active-low reset
//   load_en, load_addr, load_data   program-memory write port (IDLE only)
//   start                           run request in IDLE, halt acknowledge in HALTED
//   rd_sel -> rd_data               combinational data-register read
//   instruct                        opcode for the downstream pulse gate (STP code when not executing)
//   pc, busy, done                  program counter, FETCH/EXEC indicator, HALTED indicator
module paper_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_en,
  input  logic [3:0] load_addr,
  input  logic [7:0] load_data,
  input  logic       start,
  input  logic [1:0] rd_sel,
  output logic [7:0] rd_data,
  output logic [1:0] instruct,
  output logic [3:0] pc,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALTED} state_t;

  localparam logic [1:0] OP_INC = 2'b00;
  localparam logic [1:0] OP_DEC = 2'b01;
  localparam logic [1:0] OP_STP = 2'b10;
  localparam logic [1:0] OP_JNZ = 2'b11;

  state_t          state, state_nxt;
  logic [7:0]      mem [16];
  logic [7:0]      ir, ir_nxt;
  logic [3:0]      pc_nxt;
  logic [3:0][7:0] rf, rf_nxt;
  logic            mem_we;
  logic [1:0]      rn;
  logic [3:0]      pc_inc;

  assign rn      = ir[5:4];
  assign pc_inc  = pc + 4'd1;       // wraps 15 -> 0 by width
  assign rd_data = rf[rd_sel];      // pre-update value during EXEC

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    rf_nxt    = rf;
    mem_we    = 1'b0;
    instruct  = OP_STP;             // gate closed unless executing
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        // A write wins over start when both arrive together.
        if (load_en) begin
          mem_we = rst_n;
        end else if (start) begin
          pc_nxt    = 4'd0;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        busy      = 1'b1;
        instruct  = 2'b00;
        ir_nxt    = mem[pc];
        state_nxt = EXEC;
      end
      EXEC: begin
        busy      = 1'b1;
        instruct  = ir[7:6];
        state_nxt = FETCH;
        case (ir[7:6])
          OP_INC: begin
            rf_nxt[rn] = rf[rn] + 8'd1;
            pc_nxt     = pc_inc;
          end
          OP_DEC: begin
            if (rf[rn] != 8'd0) rf_nxt[rn] = rf[rn] - 8'd1;
            pc_nxt = pc_inc;
          end
          OP_STP: begin
            state_nxt = HALTED;
          end
          OP_JNZ: begin
            pc_nxt = (rf[rn] != 8'd0) ? ir[3:0] : pc_inc;
          end
        endcase
      end
      HALTED: begin
        done = 1'b1;
        if (start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset discards whatever update was pending, including one computed in EXEC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= 4'd0;
      ir    <= 8'h80;
      rf    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
      rf    <= rf_nxt;
    end
  end

  // Program memory survives reset; mem_we is already qualified by rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) mem[load_addr] <= load_data;
  end

endmodule

// File: tb/tb_paper_sequencer.sv
module tb_paper_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_en;
  logic [3:0] load_addr;
  logic [7:0] load_data;
  logic       start;
  logic [1:0] rd_sel;
  logic [7:0] rd_data;
  logic [1:0] instruct;
  logic [3:0] pc;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;
  int cyc;

  paper_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .start     (start),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .instruct  (instruct),
    .pc        (pc),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] sel, input logic [7:0] exp);
    rd_sel = sel;
    #1;
    chk(tag, 16'(rd_data), 16'(exp));
  endtask

  task automatic chk_pc(input string tag, input logic [3:0] exp);
    chk(tag, 16'(pc), 16'(exp));
  endtask

  // Packs {instruct, busy, done} into one comparison.
  task automatic chk_st(input string tag, input logic [1:0] ins, input logic b, input logic d);
    chk(tag, 16'({instruct, busy, done}), 16'({ins, b, d}));
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick(1);
    load_en   = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_reset;
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  // Counts edges after the start edge until done rises, bounded by limit.
  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (!done && n < limit) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    load_en   = 1'b0;
    load_addr = 4'd0;
    load_data = 8'd0;
    start     = 1'b0;
    rd_sel    = 2'd0;
    tick(2);
    rst_n = 1'b1;

    // Reset state
    chk_st("rst_status", 2'b10, 1'b0, 1'b0);
    chk_pc("rst_pc", 4'd0);
    for (int i = 0; i < 4; i++) chk_reg("rst_reg", 2'(i), 8'd0);

    // INC R0 ; STP -> two instructions, done four edges after the start edge
    load(4'd0, 8'h00);
    load(4'd1, 8'h80);
    pulse_start();
    wait_done(50, cyc);
    chk("basic_cycles", 16'(cyc), 16'd4);
    chk_reg("basic_r0", 2'd0, 8'd1);
    chk_pc("basic_pc", 4'd1);
    chk_st("basic_halt", 2'b10, 1'b0, 1'b1);

    // start in HALTED returns to IDLE with registers and PC retained
    pulse_start();
    chk_st("halt_to_idle", 2'b10, 1'b0, 1'b0);
    chk_reg("halt_keep_r0", 2'd0, 8'd1);
    chk_pc("halt_keep_pc", 4'd1);

    // Collision: write mem[1]=DEC R0 with start high; must stay IDLE
    load_en   = 1'b1;
    load_addr = 4'd1;
    load_data = 8'h40;
    start     = 1'b1;
    tick(1);
    load_en   = 1'b0;
    start     = 1'b0;
    chk_st("coll_idle", 2'b10, 1'b0, 1'b0);
    load(4'd2, 8'h80);
    // INC R0 (1->2), DEC R0 (2->1), STP: only reaches pc=2 if the colliding write landed
    pulse_start();
    wait_done(50, cyc);
    chk("coll_cycles", 16'(cyc), 16'd6);
    chk_reg("coll_r0", 2'd0, 8'd1);
    chk_pc("coll_pc", 4'd2);

    // Countdown loop: INC R1 x3, DEC R1, JNZ R1,3, STP.
    // Ten instructions executed (3 INC, 3x DEC/JNZ, STP) at 2 cycles each.
    pulse_reset();
    load(4'd0, 8'h10);
    load(4'd1, 8'h10);
    load(4'd2, 8'h10);
    load(4'd3, 8'h50);
    load(4'd4, 8'hD3);
    load(4'd5, 8'h80);
    pulse_start();
    // A write attempt while running must be dropped (would overwrite the STP).
    load_en   = 1'b1;
    load_addr = 4'd5;
    load_data = 8'h00;
    wait_done(200, cyc);
    load_en   = 1'b0;
    chk("loop_cycles", 16'(cyc), 16'd20);
    chk_reg("loop_r1", 2'd1, 8'd0);
    chk_pc("loop_pc", 4'd5);

    // Wrap and saturate: INC R2 / JNZ R2,0 until R2 wraps to 0, then DEC R2 on 0, STP.
    // 256 x (INC+JNZ) = 1024 cycles, plus DEC and STP = 1028.
    pulse_reset();
    load(4'd0, 8'h20);
    load(4'd1, 8'hE0);
    load(4'd2, 8'h60);
    load(4'd3, 8'h80);
    pulse_start();
    wait_done(2000, cyc);
    chk("wrap_cycles", 16'(cyc), 16'd1028);
    chk_reg("wrap_sat_r2", 2'd2, 8'd0);
    chk_pc("wrap_pc", 4'd3);

    // PC wrap: sixteen INC R3, 32 cycles later R3=16 and PC back at 0, still running
    pulse_reset();
    for (int i = 0; i < 16; i++) load(4'(i), 8'h30);
    pulse_start();
    tick(32);
    chk_reg("pcwrap_r3", 2'd3, 8'd16);
    chk_pc("pcwrap_pc", 4'd0);
    chk_st("pcwrap_fetch", 2'b00, 1'b1, 1'b0);

    // Now in EXEC of INC R3: read shows the pre-update value
    tick(1);
    chk_st("exec_status", 2'b00, 1'b1, 1'b0);
    chk_reg("exec_pre_r3", 2'd3, 8'd16);

    // Reset mid-EXEC aborts the update and clears registers
    pulse_reset();
    chk_st("midrst_status", 2'b10, 1'b0, 1'b0);
    chk_pc("midrst_pc", 4'd0);
    for (int i = 0; i < 4; i++) chk_reg("midrst_reg", 2'(i), 8'd0);

    // Program memory survived: two more INC R3 complete in four edges
    pulse_start();
    tick(4);
    chk_reg("mem_kept_r3", 2'd3, 8'd2);
    chk_pc("mem_kept_pc", 4'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
